// File: rtl/p_fadd_arb_if.sv
// Request/response handshake bundle between requesters and the shared FP add/sub arbiter.
// master = requesters and result consumer, slave = arbiter.
interface p_fadd_arb_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      req_op;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [IDW-1:0]       resp_id;
   logic [31:0]          resp_data;
   logic                 resp_ovf;
   logic                 resp_unf;

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_data, resp_ovf, resp_unf
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_id, resp_data, resp_ovf, resp_unf
   );
endinterface

// File: rtl/p_fadd_arb.sv
// Round-robin sharing of one LAT-stage FP add/sub unit; issue to response is LAT cycles.
// A stalled response (valid && !ready) freezes the unit, shadow pipeline and pointer; bubbles never stall.
module p_fadd_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   p_fadd_arb_if.slave       bus,
   output logic [1:0]        in_flight,
   output logic              fu_en,
   output logic [31:0]       fu_in1,
   output logic [31:0]       fu_in2,
   output logic              fu_op,
   input  logic [31:0]       fu_out,
   input  logic              fu_overflow,
   input  logic              fu_underflow
);

   logic [LAT-1:0] vld_q, vld_d;
   logic [IDW-1:0] tag_q [LAT];
   logic [IDW-1:0] tag_d [LAT];
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   logic           advance;
   logic           grant;
   logic           found;
   logic [IDW-1:0] g;
   logic [IDW:0]   idx;

   always_comb begin
      advance = !(vld_q[LAT-1] && !bus.resp_ready);
      fu_en   = advance;

      // Scan from rr_ptr upward; rr_ptr < NREQ so one subtraction wraps the index.
      g     = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
         if (!found && bus.req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            g     = idx[IDW-1:0];
         end
      end
      grant = advance && found;

      bus.req_ready = '0;
      if (grant) bus.req_ready[g] = 1'b1;

      fu_in1 = '0;
      fu_in2 = '0;
      fu_op  = 1'b0;
      if (grant) begin
         fu_in1 = bus.req_a[int'(g)*32 +: 32];
         fu_in2 = bus.req_b[int'(g)*32 +: 32];
         fu_op  = bus.req_op[g];
      end

      vld_d    = vld_q;
      tag_d    = tag_q;
      rr_ptr_d = rr_ptr_q;
      if (advance) begin
         vld_d[0] = grant;
         tag_d[0] = g;
         for (int k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            tag_d[k] = tag_q[k-1];
         end
         if (grant) rr_ptr_d = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
      end

      in_flight = '0;
      for (int k = 0; k < LAT; k++) begin
         in_flight = in_flight + {1'b0, vld_q[k]};
      end
   end

   // Result data comes straight from the unit; the shadow pipeline supplies valid and ID.
   assign bus.resp_valid = vld_q[LAT-1];
   assign bus.resp_id    = tag_q[LAT-1];
   assign bus.resp_data  = fu_out;
   assign bus.resp_ovf   = fu_overflow;
   assign bus.resp_unf   = fu_underflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= '0;
         rr_ptr_q <= '0;
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         vld_q    <= vld_d;
         rr_ptr_q <= rr_ptr_d;
         for (int k = 0; k < LAT; k++) tag_q[k] <= tag_d[k];
      end
   end

endmodule

// File: tb/tb_p_fadd_arb.sv
// Directed bench for p_fadd_arb with a behavioural 2-stage stand-in for the FP unit.
module tb_p_fadd_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int LAT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_flight;
   logic        fu_en;
   logic [31:0] fu_in1, fu_in2;
   logic        fu_op;
   logic [31:0] fu_out;
   logic        fu_overflow, fu_underflow;

   logic [31:0] a_v [NREQ];
   logic [31:0] b_v [NREQ];
   logic        op_v [NREQ];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   p_fadd_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   p_fadd_arb #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .in_flight    (in_flight),
      .fu_en        (fu_en),
      .fu_in1       (fu_in1),
      .fu_in2       (fu_in2),
      .fu_op        (fu_op),
      .fu_out       (fu_out),
      .fu_overflow  (fu_overflow),
      .fu_underflow (fu_underflow)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[32*i +: 32] = a_v[i];
         bus.req_b[32*i +: 32] = b_v[i];
         bus.req_op[i]         = op_v[i];
      end
   end

   // Stand-in FP unit: exact results for the known vectors, integer add/sub otherwise.
   function automatic logic [33:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
      if (a == 32'h3F800000 && b == 32'h40000000 && !op) return {2'b00, 32'h40400000};
      if (a == 32'h40400000 && b == 32'h3F800000 && op)  return {2'b00, 32'h40000000};
      if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !op) return {2'b10, 32'h7F800000};
      return {2'b00, op ? a - b : a + b};
   endfunction

   logic [33:0] st1, st2;
   always @(posedge clk) begin
      if (rst) begin
         st1 <= '0;
         st2 <= '0;
      end else if (fu_en) begin
         st1 <= fp_model(fu_in1, fu_in2, fu_op);
         st2 <= st1;
      end
   end
   assign fu_out       = st2[31:0];
   assign fu_overflow  = st2[33];
   assign fu_underflow = st2[32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic default_ops();
      for (int i = 0; i < NREQ; i++) begin
         a_v[i]  = 32'(i + 1);
         b_v[i]  = 32'h10 * 32'(i + 1);
         op_v[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] rv;
      logic       rr;
      logic [3:0] rdy;
      logic       en;
      logic       rvld;
      logic [1:0] id;
      logic [1:0] inf;
   } vec_t;

   vec_t vt [17];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0};
      vt[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0};
      vt[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 2'd1};
      vt[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd0, 2'd2};
      vt[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd1, 2'd2};
      vt[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 2'd2};
      vt[6]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 2'd2};
      vt[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd2, 2'd2};
      vt[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 2'd2};
      vt[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2};
      vt[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd1};
      vt[11] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd1};
      vt[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd3, 2'd1};
      vt[13] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd1};
      vt[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd2};
      vt[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd1};
      vt[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0};

      default_ops();
      do_reset();
      rst = 1'b1;
      tick();
      chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset in_flight", 32'(in_flight), 32'd0);
      chk("reset fu_en", 32'(fu_en), 32'd1);
      rst = 1'b0;

      // Single add on requester 0
      a_v[0] = 32'h3F800000; b_v[0] = 32'h40000000;
      bus.req_valid = 4'b0001;
      #1 chk("single rdy", 32'(bus.req_ready), 32'h1);
      chk("single fu_in1", fu_in1, 32'h3F800000);
      tick();
      bus.req_valid = '0;
      #1 chk("single rdy drop", 32'(bus.req_ready), 32'h0);
      chk("single early vld", 32'(bus.resp_valid), 32'd0);
      chk("single in_flight", 32'(in_flight), 32'd1);
      tick();
      chk("single vld", 32'(bus.resp_valid), 32'd1);
      chk("single id", 32'(bus.resp_id), 32'd0);
      chk("single data", bus.resp_data, 32'h40400000);
      chk("single ovf", 32'(bus.resp_ovf), 32'd0);
      chk("single unf", 32'(bus.resp_unf), 32'd0);
      tick();

      // Subtraction on requester 2
      a_v[2] = 32'h40400000; b_v[2] = 32'h3F800000; op_v[2] = 1'b1;
      bus.req_valid = 4'b0100;
      #1 chk("sub rdy", 32'(bus.req_ready), 32'h4);
      chk("sub fu_op", 32'(fu_op), 32'd1);
      tick();
      bus.req_valid = '0;
      tick();
      chk("sub vld", 32'(bus.resp_valid), 32'd1);
      chk("sub id", 32'(bus.resp_id), 32'd2);
      chk("sub data", bus.resp_data, 32'h40000000);
      tick();

      // Overflow on requester 1
      a_v[1] = 32'h7F7FFFFF; b_v[1] = 32'h7F7FFFFF;
      bus.req_valid = 4'b0010;
      #1 chk("ovf rdy", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = '0;
      tick();
      chk("ovf vld", 32'(bus.resp_valid), 32'd1);
      chk("ovf id", 32'(bus.resp_id), 32'd1);
      chk("ovf flag", 32'(bus.resp_ovf), 32'd1);
      tick();

      // Table: arbitration, stalls, bubbles, dropped requests
      default_ops();
      do_reset();
      for (int r = 0; r < 17; r++) begin
         logic [31:0] exp_in1;
         bus.req_valid  = vt[r].rv;
         bus.resp_ready = vt[r].rr;
         #1;
         exp_in1 = '0;
         for (int j = 0; j < NREQ; j++) if (vt[r].rdy[j]) exp_in1 = 32'(j + 1);
         chk($sformatf("vec%0d rdy", r), 32'(bus.req_ready), 32'(vt[r].rdy));
         chk($sformatf("vec%0d fu_en", r), 32'(fu_en), 32'(vt[r].en));
         chk($sformatf("vec%0d fu_in1", r), fu_in1, exp_in1);
         chk($sformatf("vec%0d resp_valid", r), 32'(bus.resp_valid), 32'(vt[r].rvld));
         chk($sformatf("vec%0d in_flight", r), 32'(in_flight), 32'(vt[r].inf));
         if (vt[r].rvld) begin
            chk($sformatf("vec%0d resp_id", r), 32'(bus.resp_id), 32'(vt[r].id));
            chk($sformatf("vec%0d resp_data", r), bus.resp_data, 32'h11 * (32'(vt[r].id) + 1));
         end
         tick();
      end

      // Backpressure: three back-to-back ops, consumer stalls for 5 cycles
      do_reset();
      bus.req_valid = 4'b0111;
      #1 chk("bp rdy0", 32'(bus.req_ready), 32'h1);
      tick();
      chk("bp rdy1", 32'(bus.req_ready), 32'h2);
      tick();
      chk("bp rdy2", 32'(bus.req_ready), 32'h4);
      chk("bp first id", 32'(bus.resp_id), 32'd0);
      tick();
      bus.req_valid = 4'b1000;
      bus.resp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d fu_en", c), 32'(fu_en), 32'd0);
         chk($sformatf("bp%0d rdy", c), 32'(bus.req_ready), 32'h0);
         chk($sformatf("bp%0d vld", c), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("bp%0d id", c), 32'(bus.resp_id), 32'd1);
         chk($sformatf("bp%0d data", c), bus.resp_data, 32'h22);
         chk($sformatf("bp%0d in_flight", c), 32'(in_flight), 32'd2);
         tick();
      end
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
      #1 chk("bp drain id1", 32'(bus.resp_id), 32'd1);
      tick();
      chk("bp drain vld2", 32'(bus.resp_valid), 32'd1);
      chk("bp drain id2", 32'(bus.resp_id), 32'd2);
      chk("bp drain data2", bus.resp_data, 32'h33);
      tick();
      chk("bp drain empty", 32'(bus.resp_valid), 32'd0);
      chk("bp drain in_flight", 32'(in_flight), 32'd0);

      // Reset with two ops in flight
      do_reset();
      bus.req_valid = 4'b1111;
      tick();
      tick();
      bus.req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 chk("mid rst vld", 32'(bus.resp_valid), 32'd0);
      chk("mid rst in_flight", 32'(in_flight), 32'd0);
      bus.req_valid = 4'b1111;
      #1 chk("mid rst first grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      chk("mid rst no stale", 32'(bus.resp_valid), 32'd0);
      chk("mid rst in_flight1", 32'(in_flight), 32'd1);
      tick();
      chk("mid rst resp vld", 32'(bus.resp_valid), 32'd1);
      chk("mid rst resp id", 32'(bus.resp_id), 32'd0);
      chk("mid rst resp data", bus.resp_data, 32'h11);
      tick();
      chk("mid rst after", 32'(bus.resp_valid), 32'd0);

      // Continuous round-robin over all requesters
      do_reset();
      for (int c = 0; c < 11; c++) begin
         logic [1:0] exp_inf;
         bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         exp_inf = (c == 0 || c == 10) ? 2'd0 : (c == 1 || c == 9) ? 2'd1 : 2'd2;
         chk($sformatf("rr%0d rdy", c), 32'(bus.req_ready), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
         chk($sformatf("rr%0d in_flight", c), 32'(in_flight), 32'(exp_inf));
         chk($sformatf("rr%0d vld", c), 32'(bus.resp_valid), (c >= 2 && c < 10) ? 32'd1 : 32'd0);
         if (c >= 2 && c < 10) chk($sformatf("rr%0d id", c), 32'(bus.resp_id), 32'((c - 2) % 4));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/p_fadd_arb.md
Name: p_fadd_arb

Overview:
- Round-robin arbiter and sequencer that shares one 2-stage pipelined FP add/sub unit (p_fadd_sub) among NREQ requesters.
- Accepts operations over per-requester valid/ready handshakes and drives the unit's en, in1, in2 and op inputs.
- Tracks in-flight operations with a valid/tag shadow pipeline and returns each result, tagged with its requester ID, on a single response channel with backpressure.
- Sits between the requesting blocks and the p_fadd_sub instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, tag width; must satisfy 2^IDW >= NREQ.
- LAT, 2, register stages in the FP unit between the issue edge and valid output (align->calc, calc->norm).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  operation request, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero.
- req_a  in  32*NREQ  operand 1; requester i occupies bits [32i+31:32i].
- req_b  in  32*NREQ  operand 2, same packing as req_a.
- req_op  in  NREQ  1 = sub, 0 = add.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index of the result.
- resp_data  out  32  IEEE-754 single-precision result.
- resp_ovf  out  1  overflow flag of the result.
- resp_unf  out  1  underflow flag of the result.
- in_flight  out  2  number of valid operations in the FP unit (0..LAT).
- fu_en  out  1  drives the FP unit en.
- fu_in1  out  32  drives the FP unit in1.
- fu_in2  out  32  drives the FP unit in2.
- fu_op  out  1  drives the FP unit op.
- fu_out  in  32  FP unit result.
- fu_overflow  in  1  FP unit overflow.
- fu_underflow  in  1  FP unit underflow.

Behaviour:
- State:
  - vld[0..LAT-1] and tag[0..LAT-1] shadow the unit's stage registers.
  - rr_ptr (IDW bits) is the round-robin priority pointer.
  - The FP unit shares clk/rst with this block.
- Reset (rst=1 at a posedge): vld all 0, tag all 0, rr_ptr=0. Consequently resp_valid=0, req_ready=0, in_flight=0, fu_en=1.
- Stall:
  - advance = !(vld[LAT-1] && !resp_ready); fu_en = advance.
  - While advance=0, the unit, the shadow pipeline and rr_ptr all hold, and req_ready=0.
- Arbitration (combinational):
  - The winner g is the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ.
  - grant = advance && any(req_valid).
  - req_ready[g] = grant; all other bits are 0.
- Issue:
  - When grant=1: fu_in1=req_a[g], fu_in2=req_b[g], fu_op=req_op[g].
  - Otherwise fu_in1=0, fu_in2=0, fu_op=0 (bubble).
  - On a posedge with advance=1: vld[0]<=grant, tag[0]<=g, vld[k]<=vld[k-1], tag[k]<=tag[k-1].
  - If grant=1, rr_ptr <= (g+1) mod NREQ; otherwise rr_ptr holds.
- Response:
  - resp_valid=vld[LAT-1], resp_id=tag[LAT-1].
  - resp_data, resp_ovf and resp_unf are passed through combinationally from fu_out, fu_overflow and fu_underflow.
  - When resp_valid=0, the data outputs are don't-care; the bench must not check them.
- Latency and throughput:
  - With no stall, a request accepted at edge t appears with resp_valid=1 in the cycle following edge t+LAT-1, i.e. LAT cycles after acceptance.
  - Throughput is 1 op/cycle. A result and a new issue in the same cycle are legal when resp_ready=1.
- Backpressure: while resp_valid=1 and resp_ready=0, resp_id, resp_data and the flags stay stable, and no request is accepted.
- Bubbles: bubbles never stall the pipeline. With vld[LAT-1]=0, advance=1 regardless of resp_ready.
- in_flight = popcount(vld).
- Ordering: responses leave strictly in issue order.
- Requester rules:
  - Requesters must hold req_valid and operands stable until ready.
  - A requester dropping req_valid without ready is tolerated; nothing is issued for it.
- Reset mid-operation discards all in-flight ops. No response is produced for them.

Test Plan:
- Single op: req 0 valid, a=0x3F800000, b=0x40000000, op=0, resp_ready=1 -> req_ready[0]=1 for one cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data=0x40400000, ovf=0, unf=0.
- Subtraction on requester 2: a=0x40400000, b=0x3F800000, op=1 -> resp_id=2, resp_data=0x40000000.
- Round-robin: all 4 requesters continuously valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses carry the same ID order, one per cycle, in_flight=2 in steady state.
- Backpressure: issue 3 back-to-back ops, hold resp_ready=0 for 5 cycles once resp_valid=1:
  - fu_en=0, req_ready=0, resp_id and resp_data stable, in_flight=2.
  - After releasing resp_ready, the remaining results drain in order with no loss or duplication.
- Overflow: a=b=0x7F7FFFFF, op=0 -> resp_valid with resp_ovf=1.
- Reset mid-flight: assert rst for 1 cycle with 2 ops in flight -> resp_valid=0 from the next cycle, in_flight=0, the first grant after reset goes to requester 0, and no stale response appears.
